// File: rtl/algo_t1_1r1w_mem_resp_if.sv
// t1 physical-memory bus: write port A, read port B, plus status back to the driver.
interface algo_t1_1r1w_mem_resp_if #(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned BITADDR = 12
);
  logic               ready;
  logic               t1_writeA;
  logic [BITADDR-1:0] t1_addrA;
  logic [WIDTH-1:0]   t1_dinA;
  logic [WIDTH-1:0]   t1_bwA;
  logic               t1_readB;
  logic [BITADDR-1:0] t1_addrB;
  logic [WIDTH-1:0]   t1_doutB;
  logic               t1_vldB;
  logic               t1_err;

  // Algorithm top side: issues accesses, consumes read data and status.
  modport master (
    output t1_writeA, t1_addrA, t1_dinA, t1_bwA, t1_readB, t1_addrB,
    input  ready, t1_doutB, t1_vldB, t1_err
  );

  // Memory responder side.
  modport slave (
    input  t1_writeA, t1_addrA, t1_dinA, t1_bwA, t1_readB, t1_addrB,
    output ready, t1_doutB, t1_vldB, t1_err
  );
endinterface

// File: rtl/algo_t1_1r1w_mem_resp.sv
// One physical t1 bank: self-initialising after reset, bit-masked writes on port A,
// fixed-latency pipelined reads on port B, sticky protocol-error flag.
module algo_t1_1r1w_mem_resp #(
  parameter int unsigned     WIDTH   = 128,
  parameter int unsigned     NUMADDR = 4096,
  parameter int unsigned     BITADDR = 12,
  parameter int unsigned     DELAY   = 1,
  parameter logic [WIDTH-1:0] INITVAL = '0
) (
  input logic                    clk,
  input logic                    rst,
  algo_t1_1r1w_mem_resp_if.slave t1
);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  localparam logic [BITADDR:0]   NumAddr  = (BITADDR + 1)'(NUMADDR);
  localparam logic [BITADDR-1:0] LastAddr = BITADDR'(NUMADDR - 1);

  state_e             state;
  logic [BITADDR-1:0] init_cnt;
  logic               ready_q;
  logic               err_q;
  logic               vld_q;
  logic [WIDTH-1:0]   dout_q;
  logic [WIDTH-1:0]   mem [NUMADDR];

  logic             wr_in_range, rd_in_range;
  logic             wr_fire, rd_fire, err_set;
  logic [WIDTH-1:0] rd_data;
  logic             fin_vld;
  logic [WIDTH-1:0] fin_data;

  assign wr_in_range = {1'b0, t1.t1_addrA} < NumAddr;
  assign rd_in_range = {1'b0, t1.t1_addrB} < NumAddr;
  assign wr_fire     = ready_q & t1.t1_writeA & wr_in_range;
  // Out-of-range reads still answer, with zero data.
  assign rd_fire     = ready_q & t1.t1_readB;
  assign rd_data     = rd_in_range ? mem[t1.t1_addrB] : '0;
  assign err_set     = (~ready_q & (t1.t1_writeA | t1.t1_readB))
                     | (ready_q & t1.t1_writeA & ~wr_in_range)
                     | (ready_q & t1.t1_readB & ~rd_in_range);

  // Init-sweep FSM with registered ready and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StInit;
      init_cnt <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (err_set) err_q <= 1'b1;
      case (state)
        StInit: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LastAddr) begin
            state   <= StReady;
            ready_q <= 1'b1;
          end
        end
        StReady: ;
        default: state <= StInit;
      endcase
    end
  end

  // Array update: sweep writes during init, masked writes once ready. Not cleared by rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == StInit) begin
        mem[init_cnt] <= INITVAL;
      end else if (wr_fire) begin
        mem[t1.t1_addrA] <= (mem[t1.t1_addrA] & ~t1.t1_bwA) | (t1.t1_dinA & t1.t1_bwA);
      end
    end
  end

  // DELAY-1 internal stages; the output register supplies the final cycle of latency.
  if (DELAY == 1) begin : g_nopipe
    assign fin_vld  = rd_fire;
    assign fin_data = rd_data;
  end else begin : g_pipe
    logic             vld_pipe  [DELAY-1];
    logic [WIDTH-1:0] data_pipe [DELAY-1];

    // Read-data shift pipeline; rst drops everything in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DELAY) - 1; i++) vld_pipe[i] <= 1'b0;
      end else begin
        vld_pipe[0]  <= rd_fire;
        data_pipe[0] <= rd_data;
        for (int i = 1; i < int'(DELAY) - 1; i++) begin
          vld_pipe[i]  <= vld_pipe[i-1];
          data_pipe[i] <= data_pipe[i-1];
        end
      end
    end

    assign fin_vld  = vld_pipe[DELAY-2];
    assign fin_data = data_pipe[DELAY-2];
  end

  // Output stage: vld pulses, dout holds the last returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      vld_q <= fin_vld;
      if (fin_vld) dout_q <= fin_data;
    end
  end

  assign t1.ready    = ready_q;
  assign t1.t1_vldB  = vld_q;
  assign t1.t1_doutB = dout_q;
  assign t1.t1_err   = err_q;

endmodule

// File: tb/tb_algo_t1_1r1w_mem_resp.sv
// Randomised bench for the t1 memory responder against a cycle-keyed behavioural model.
module tb_algo_t1_1r1w_mem_resp;

  localparam int unsigned     W   = 32;
  localparam int unsigned     N   = 12;
  localparam int unsigned     BA  = 4;
  localparam int unsigned     DLY = 3;
  localparam logic [W-1:0]    IV  = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  algo_t1_1r1w_mem_resp_if #(.WIDTH(W), .BITADDR(BA)) bus ();

  algo_t1_1r1w_mem_resp #(
    .WIDTH(W), .NUMADDR(N), .BITADDR(BA), .DELAY(DLY), .INITVAL(IV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .t1 (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [W-1:0] m_mem [N];
  logic [W-1:0] due [int];  // expected read data keyed by the cycle it must appear
  int           rel_cnt = 0;  // cycles since reset released
  int           now_cyc = 0;
  logic         m_err = 1'b0;
  logic [W-1:0] m_dout = '0;

  function automatic logic [W-1:0] z1(input logic b);
    return {{(W-1){1'b0}}, b};
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, now_cyc);
    end
  endtask

  task automatic drive(input logic w, input int aa, input logic [W-1:0] din,
                       input logic [W-1:0] bw, input logic r, input int ab);
    bus.t1_writeA = w;
    bus.t1_addrA  = BA'(aa);
    bus.t1_dinA   = din;
    bus.t1_bwA    = bw;
    bus.t1_readB  = r;
    bus.t1_addrB  = BA'(ab);
  endtask

  task automatic idle();
    drive(1'b0, 0, '0, '0, 1'b0, 0);
  endtask

  // Apply the current inputs for one cycle, update the model, then check outputs.
  task automatic tick();
    int           aa, ab;
    logic         ev;
    logic [W-1:0] d;
    aa = int'(bus.t1_addrA);
    ab = int'(bus.t1_addrB);
    if (rst) begin
      rel_cnt = 0;
      m_err   = 1'b0;
      m_dout  = '0;
      due.delete();
    end else begin
      if (rel_cnt < int'(N)) begin
        if (bus.t1_writeA || bus.t1_readB) m_err = 1'b1;
      end else begin
        // Read samples before the same-cycle write lands.
        if (bus.t1_readB) begin
          if (ab < int'(N)) d = m_mem[ab];
          else begin
            d     = '0;
            m_err = 1'b1;
          end
          due[now_cyc + int'(DLY)] = d;
        end
        if (bus.t1_writeA) begin
          if (aa < int'(N)) m_mem[aa] = (m_mem[aa] & ~bus.t1_bwA) | (bus.t1_dinA & bus.t1_bwA);
          else m_err = 1'b1;
        end
      end
      rel_cnt++;
      if (rel_cnt == int'(N)) foreach (m_mem[i]) m_mem[i] = IV;
    end
    @(posedge clk);
    #1;
    now_cyc++;
    ev = due.exists(now_cyc);
    if (ev) begin
      m_dout = due[now_cyc];
      due.delete(now_cyc);
    end
    check_eq("ready", z1(bus.ready), z1(rel_cnt >= int'(N)));
    check_eq("vldB", z1(bus.t1_vldB), z1(ev));
    check_eq("doutB", bus.t1_doutB, m_dout);
    check_eq("err", z1(bus.t1_err), z1(m_err));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) tick();

    // Sweep, then an access during INIT, then reset at init_cnt=7.
    rst = 1'b0;
    repeat (3) tick();
    drive(1'b0, 0, '0, '0, 1'b1, 2);
    tick();
    idle();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (N + 2) tick();

    // Back-to-back readback of every row after the sweep.
    for (int r = 0; r < int'(N); r++) begin
      drive(1'b0, 0, '0, '0, 1'b1, r);
      tick();
    end
    idle();
    repeat (DLY + 2) tick();

    // Masked write, zero-mask write, readback.
    drive(1'b1, 3, '1, 32'h0000_00FF, 1'b0, 0);
    tick();
    drive(1'b1, 4, 32'h0F0F_0F0F, '0, 1'b0, 0);
    tick();
    drive(1'b0, 0, '0, '0, 1'b1, 3);
    tick();
    drive(1'b0, 0, '0, '0, 1'b1, 4);
    tick();
    idle();
    repeat (DLY + 1) tick();

    // Same-cycle read/write collision, then read the new value.
    drive(1'b1, 5, 32'h0000_1234, '1, 1'b1, 5);
    tick();
    drive(1'b0, 0, '0, '0, 1'b1, 5);
    tick();
    idle();
    repeat (DLY + 1) tick();

    // Random in-range traffic.
    repeat (300) begin
      drive(1'($urandom), int'($urandom_range(0, N - 1)), W'($urandom),
            ($urandom_range(0, 7) == 0) ? '0 : W'($urandom),
            1'($urandom), int'($urandom_range(0, N - 1)));
      tick();
    end
    idle();
    repeat (DLY + 1) tick();

    // Out-of-range write and read.
    drive(1'b1, 13, '1, '1, 1'b0, 0);
    tick();
    drive(1'b0, 0, '0, '0, 1'b1, 13);
    tick();
    idle();
    repeat (DLY + 1) tick();

    // Random traffic across the full address space.
    repeat (100) begin
      drive(1'($urandom), int'($urandom_range(0, 15)), W'($urandom), W'($urandom),
            1'($urandom), int'($urandom_range(0, 15)));
      tick();
    end
    idle();
    repeat (DLY + 1) tick();

    // Reset with a read in flight: it must never return.
    drive(1'b0, 0, '0, '0, 1'b1, 7);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (N + DLY + 2) tick();
    drive(1'b0, 0, '0, '0, 1'b1, 7);
    tick();
    idle();
    repeat (DLY + 1) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
